// File: rtl/mtr_pwm_pkg.sv
// ----------------------------------------------------------------------------
// mtr_pwm_pkg
// Shared types, widths and helpers for the motor PWM driver.
//   pwm_state_t : driver sequencing states (IDLE, RAMP, TRACK, BRAKE)
//   PWM_W       : width of the PWM counter and of the duty value
//   MAG_W       : width of the drive magnitude coming from the PID block
//   SLEW_DIV_W  : width of the period counter that decimates slew ticks
//   DUTY_CAP    : highest duty allowed when MTR_PWM_DUTY_CAP_EN is defined
//   slew_up()   : one slew-limited step towards a higher target, no wrap
// ----------------------------------------------------------------------------
package mtr_pwm_pkg;

    localparam int PWM_W      = 11;
    localparam int MAG_W      = 12;
    localparam int SLEW_DIV_W = 4;

    localparam logic [PWM_W-1:0] DUTY_CAP = 11'h7C0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        TRACK = 2'd2,
        BRAKE = 2'd3
    } pwm_state_t;

    // The sum is one bit wider so a step near full scale saturates at the
    // target instead of wrapping back to a small duty.
    function automatic logic [PWM_W-1:0] slew_up(input logic [PWM_W-1:0] cur,
                                                 input logic [PWM_W-1:0] tgt,
                                                 input logic [PWM_W-1:0] step);
        logic [PWM_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        return (sum > {1'b0, tgt}) ? tgt : sum[PWM_W-1:0];
    endfunction

endpackage

// File: rtl/mtr_pwm_drv_if.sv
// ----------------------------------------------------------------------------
// mtr_pwm_drv_if
// Bundle between the PID / supervisor side and the PWM driver.
//   en        : motor enable
//   brake_n   : active-low brake request, overrides en
//   drv_mag   : unsigned drive magnitude, the driver uses drv_mag[11:1]
//   pwm_hi    : high-side gate
//   pwm_lo    : low-side gate
//   duty      : duty currently applied
//   pwm_synch : one-clock pulse at the start of each PWM period
//   ramp_busy : high while the duty is still slewing up
// Modports: master = controller side, slave = the driver.
// ----------------------------------------------------------------------------
interface mtr_pwm_drv_if;
    import mtr_pwm_pkg::*;

    logic             en;
    logic             brake_n;
    logic [MAG_W-1:0] drv_mag;
    logic             pwm_hi;
    logic             pwm_lo;
    logic [PWM_W-1:0] duty;
    logic             pwm_synch;
    logic             ramp_busy;

    modport master (
        output en, brake_n, drv_mag,
        input  pwm_hi, pwm_lo, duty, pwm_synch, ramp_busy
    );

    modport slave (
        input  en, brake_n, drv_mag,
        output pwm_hi, pwm_lo, duty, pwm_synch, ramp_busy
    );

endinterface

// File: rtl/pwm_deadtime.sv
// ----------------------------------------------------------------------------
// pwm_deadtime
// Turns the raw PWM comparison into a complementary gate pair with a
// deadtime of DEADTIME clocks (both gates low) around every gate change.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_raw        : raw PWM level (cnt < duty)
//   i_force_off  : both gates off (driver idle)
//   i_force_lo   : low-side on, high-side off (brake)
//   o_pwm_hi     : high-side gate, registered
//   o_pwm_lo     : low-side gate, registered
// A change of the requested pair at clock t drives both gates low at t+1
// and applies the new pair at t+1+DEADTIME; a request that changes again
// inside the window restarts it, so short pulses never reach the gates.
// ----------------------------------------------------------------------------
module pwm_deadtime #(
    parameter logic [5:0] DEADTIME = 6'd32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    input  logic i_force_off,
    input  logic i_force_lo,
    output logic o_pwm_hi,
    output logic o_pwm_lo
);

    logic [1:0] w_req;     // {hi, lo} the gates should settle to
    logic [1:0] r_req;     // request seen on the previous clock
    logic [5:0] r_dt_cnt;

    // NOTE: combinational blocks assign every output first so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_req = {i_raw, ~i_raw};
        if (i_force_lo) begin
            w_req = 2'b01;
        end
        if (i_force_off) begin
            w_req = 2'b00;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req    <= 2'b00;
            r_dt_cnt <= '0;
            o_pwm_hi <= 1'b0;
            o_pwm_lo <= 1'b0;
        end else begin
            r_req <= w_req;
            if (w_req != r_req) begin
                r_dt_cnt <= DEADTIME;
                o_pwm_hi <= 1'b0;
                o_pwm_lo <= 1'b0;
            end else if (r_dt_cnt > 6'd1) begin
                r_dt_cnt <= r_dt_cnt - 6'd1;
                o_pwm_hi <= 1'b0;
                o_pwm_lo <= 1'b0;
            end else begin
                // Last count of the window: gates switch on this edge.
                r_dt_cnt <= '0;
                o_pwm_hi <= w_req[1];
                o_pwm_lo <= w_req[0];
            end
        end
    end

endmodule

// File: rtl/mtr_pwm_drv.sv
// ----------------------------------------------------------------------------
// mtr_pwm_drv
// Consumer of the PID drive magnitude: slew-limited 11-bit duty and a
// deadtime-protected complementary PWM pair for one half-bridge, with
// enable and brake sequencing.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mtr_pwm_drv_if.slave (en, brake_n, drv_mag in;
//                pwm_hi, pwm_lo, duty, pwm_synch, ramp_busy out)
// Parameters:
//   FAST_SIM  : 1 = slew tick every period, 0 = every 16th period
//   DEADTIME  : clocks with both gates low around each gate change
//   SLEW_STEP : maximum duty increase per slew tick
// Build option: MTR_PWM_DUTY_CAP_EN clips the target to DUTY_CAP so the
// low side always conducts long enough to recharge the bootstrap supply.
// ----------------------------------------------------------------------------
module mtr_pwm_drv
    import mtr_pwm_pkg::*;
#(
    parameter bit               FAST_SIM  = 1'b0,
    parameter logic [5:0]       DEADTIME  = 6'd32,
    parameter logic [PWM_W-1:0] SLEW_STEP = 11'd16
) (
    input logic          clk,
    input logic          rst_n,
    mtr_pwm_drv_if.slave bus
);

    pwm_state_t            r_state;
    pwm_state_t            w_state_nxt;
    logic [PWM_W-1:0]      r_cnt;
    logic [PWM_W-1:0]      r_duty;
    logic [PWM_W-1:0]      w_duty_nxt;
    logic [PWM_W-1:0]      w_ramp_duty;
    logic [PWM_W-1:0]      w_target;
    logic [SLEW_DIV_W-1:0] r_slew_div;
    logic                  r_synch;
    logic                  w_boundary;
    logic                  w_tick;
    logic                  w_gap_big;
    logic                  w_raw;
    logic                  w_force_off;
    logic                  w_force_lo;
    logic                  w_pwm_hi;
    logic                  w_pwm_lo;
    logic                  w_unused_mag_lsb;

    assign w_unused_mag_lsb = bus.drv_mag[0];

`ifdef MTR_PWM_DUTY_CAP_EN
    assign w_target = (bus.drv_mag[MAG_W-1:1] > DUTY_CAP) ? DUTY_CAP
                                                          : bus.drv_mag[MAG_W-1:1];
`else
    assign w_target = bus.drv_mag[MAG_W-1:1];
`endif

    // The duty register only moves on the last count of a period, so a new
    // value always starts cleanly at cnt==0.
    assign w_boundary = (r_cnt == '1);
    assign w_tick     = w_boundary && (FAST_SIM || (r_slew_div == '1));
    assign w_gap_big  = ({1'b0, w_target} > ({1'b0, r_duty} + {1'b0, SLEW_STEP}));

    // Down moves are applied at once; up moves wait for a slew tick.
    assign w_ramp_duty = (w_target < r_duty) ? w_target :
                         w_tick              ? slew_up(r_duty, w_target, SLEW_STEP) :
                                               r_duty;

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        case (r_state)
            IDLE: begin
                w_duty_nxt = '0;
                if (bus.en) begin
                    w_state_nxt = RAMP;
                end
            end
            RAMP: begin
                if (w_boundary) begin
                    w_duty_nxt = w_ramp_duty;
                    if (w_ramp_duty == w_target) begin
                        w_state_nxt = TRACK;
                    end
                end
            end
            TRACK: begin
                if (w_gap_big) begin
                    w_state_nxt = RAMP;
                end else if (w_boundary) begin
                    w_duty_nxt = w_target;
                end
            end
            BRAKE: begin
                w_duty_nxt = '0;
                if (bus.brake_n) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
        // Dropping enable and braking cut the duty immediately, mid-period.
        if (!bus.en && (r_state == RAMP || r_state == TRACK)) begin
            w_state_nxt = IDLE;
            w_duty_nxt  = '0;
        end
        if (!bus.brake_n) begin
            w_state_nxt = BRAKE;
            w_duty_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_duty     <= '0;
            r_slew_div <= '0;
            r_synch    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= r_cnt + 11'd1;
            r_duty  <= w_duty_nxt;
            r_synch <= (r_cnt == '0);
            if (w_boundary) begin
                r_slew_div <= r_slew_div + 4'd1;
            end
        end
    end

    // Gate forcing follows the next state so that enable-drop and brake act
    // on the gates in the same clock as on the duty.
    assign w_raw       = (r_cnt < r_duty);
    assign w_force_off = (w_state_nxt == IDLE);
    assign w_force_lo  = (w_state_nxt == BRAKE);

    pwm_deadtime #(
        .DEADTIME (DEADTIME)
    ) u_deadtime (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_raw       (w_raw),
        .i_force_off (w_force_off),
        .i_force_lo  (w_force_lo),
        .o_pwm_hi    (w_pwm_hi),
        .o_pwm_lo    (w_pwm_lo)
    );

    assign bus.pwm_hi    = w_pwm_hi;
    assign bus.pwm_lo    = w_pwm_lo;
    assign bus.duty      = r_duty;
    assign bus.pwm_synch = r_synch;
    assign bus.ramp_busy = (r_state == RAMP);

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// ----------------------------------------------------------------------------
// tb_mtr_pwm_drv
// Bench for mtr_pwm_drv with FAST_SIM=1, DEADTIME=32, SLEW_STEP=256.
// Per-period duty/busy expectations are queued when stimulus is applied and
// popped at each pwm_synch pulse; gate timing is captured over one period
// and compared against positions derived from DEADTIME.
// ----------------------------------------------------------------------------
module tb_mtr_pwm_drv;
    import mtr_pwm_pkg::*;

    localparam int         DT   = 32;
    localparam logic [10:0] STEP = 11'd256;

    typedef struct packed {
        logic [10:0] duty;
        logic        busy;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mtr_pwm_drv_if bus_if ();

    mtr_pwm_drv #(
        .FAST_SIM  (1'b1),
        .DEADTIME  (6'(DT)),
        .SLEW_STEP (STEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic hi_tr [2048];
    logic lo_tr [2048];
    logic overlap_seen = 1'b0;

    always @(negedge clk) begin
        if (bus_if.pwm_hi && bus_if.pwm_lo) overlap_seen <= 1'b1;
    end

    function automatic logic [10:0] tgt_of(input logic [11:0] mag);
        logic [10:0] t;
        t = mag[11:1];
`ifdef MTR_PWM_DUTY_CAP_EN
        if (t > DUTY_CAP) t = DUTY_CAP;
`endif
        return t;
    endfunction

    // Reference duty step at one period boundary (slew tick every period).
    function automatic logic [10:0] slew_of(input logic [10:0] d, input logic [10:0] t);
        int s;
        if (t <= d) return t;
        s = int'(d) + int'(STEP);
        return (s > int'(t)) ? t : 11'(s);
    endfunction

    // Advance to the next negedge where pwm_synch is high (cnt==1).
    task automatic wait_synch();
        int n = 0;
        @(negedge clk);
        while (!bus_if.pwm_synch && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!bus_if.pwm_synch) begin
            n_cmp++; n_bad++;
            $display("FAIL synch_timeout: no pwm_synch within 3000 clks");
        end
    endtask

    // Called at the cnt==1 negedge; records gates for cnt 1..2047.
    task automatic capture_period();
        for (int c = 1; c < 2048; c++) begin
            if (c > 1) @(negedge clk);
            hi_tr[c] = bus_if.pwm_hi;
            lo_tr[c] = bus_if.pwm_lo;
        end
    endtask

    task automatic test_reset();
        bus_if.en = 1'b0; bus_if.brake_n = 1'b1; bus_if.drv_mag = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus_if.pwm_hi, bus_if.pwm_lo, bus_if.pwm_synch, bus_if.ramp_busy, bus_if.duty} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got hi=%b lo=%b synch=%b busy=%b duty=%h, expected all 0",
                     bus_if.pwm_hi, bus_if.pwm_lo, bus_if.pwm_synch, bus_if.ramp_busy, bus_if.duty);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bus_if.duty !== 11'd0 || bus_if.ramp_busy !== 1'b0 || bus_if.pwm_hi !== 1'b0 || bus_if.pwm_lo !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: duty=%h busy=%b hi=%b lo=%b, expected 0/0/0/0",
                     bus_if.duty, bus_if.ramp_busy, bus_if.pwm_hi, bus_if.pwm_lo);
        end
    endtask

    task automatic test_ramp();
        logic [10:0] d, t;
        exp_t e;
        wait_synch();
        bus_if.drv_mag = 12'hFFF;
        bus_if.en      = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus_if.ramp_busy !== 1'b1 || bus_if.duty !== 11'd0) begin
            n_bad++;
            $display("FAIL ramp_entry: busy=%b duty=%h, expected busy=1 duty=000", bus_if.ramp_busy, bus_if.duty);
        end
        d = 11'd0;
        t = tgt_of(12'hFFF);
        for (int i = 0; i < 16 && d != t; i++) begin
            d = slew_of(d, t);
            sb_q.push_back('{duty: d, busy: (d != t)});
        end
        while (sb_q.size() > 0) begin
            wait_synch();
            e = sb_q.pop_front();
            n_cmp++;
            if (bus_if.duty !== e.duty || bus_if.ramp_busy !== e.busy) begin
                n_bad++;
                $display("FAIL ramp_period: duty=%h busy=%b, expected duty=%h busy=%b",
                         bus_if.duty, bus_if.ramp_busy, e.duty, e.busy);
            end
        end
    endtask

    task automatic test_track_down();
        exp_t e;
        bus_if.drv_mag = 12'h800;
        repeat (100) @(negedge clk);
        n_cmp++;
        if (bus_if.duty !== tgt_of(12'hFFF) || bus_if.ramp_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL track_mid_period: duty=%h busy=%b, expected duty=%h busy=0",
                     bus_if.duty, bus_if.ramp_busy, tgt_of(12'hFFF));
        end
        sb_q.push_back('{duty: tgt_of(12'h800), busy: 1'b0});
        wait_synch();
        bus_if.drv_mag = 12'h200;
        sb_q.push_back('{duty: tgt_of(12'h200), busy: 1'b0});
        while (sb_q.size() > 0) begin
            if (sb_q.size() == 1) wait_synch();
            e = sb_q.pop_front();
            n_cmp++;
            if (bus_if.duty !== e.duty || bus_if.ramp_busy !== e.busy) begin
                n_bad++;
                $display("FAIL track_down: duty=%h busy=%b, expected duty=%h busy=%b",
                         bus_if.duty, bus_if.ramp_busy, e.duty, e.busy);
            end
        end
    endtask

    task automatic test_deadtime();
        exp_t e;
        int   hi_cnt;
        // Steady duty 0x100: raw rises at cnt 0 and falls at cnt 0x100.
        wait_synch();
        capture_period();
        n_cmp++;
        if (lo_tr[1] !== 1'b0 || hi_tr[1] !== 1'b0) begin
            n_bad++; $display("FAIL dt_rise_lo_off: lo=%b hi=%b at cnt 1, expected 0/0", lo_tr[1], hi_tr[1]);
        end
        n_cmp++;
        if (hi_tr[DT] !== 1'b0 || hi_tr[DT+1] !== 1'b1) begin
            n_bad++; $display("FAIL dt_rise_hi_on: hi=%b,%b at cnt %0d,%0d, expected 0,1", hi_tr[DT], hi_tr[DT+1], DT, DT+1);
        end
        n_cmp++;
        if (hi_tr[11'h100] !== 1'b1 || hi_tr[11'h101] !== 1'b0) begin
            n_bad++; $display("FAIL dt_fall_hi_off: hi=%b,%b at cnt 100,101, expected 1,0", hi_tr[11'h100], hi_tr[11'h101]);
        end
        n_cmp++;
        if (lo_tr[11'h101+DT-1] !== 1'b0 || lo_tr[11'h101+DT] !== 1'b1 || lo_tr[2047] !== 1'b1) begin
            n_bad++; $display("FAIL dt_fall_lo_on: lo=%b,%b,%b, expected 0,1,1",
                              lo_tr[11'h101+DT-1], lo_tr[11'h101+DT], lo_tr[2047]);
        end
        // Duty 0x010 is shorter than the deadtime: high side must stay off.
        wait_synch();
        bus_if.drv_mag = 12'h020;
        sb_q.push_back('{duty: tgt_of(12'h020), busy: 1'b0});
        wait_synch();
        e = sb_q.pop_front();
        n_cmp++;
        if (bus_if.duty !== e.duty || bus_if.ramp_busy !== e.busy) begin
            n_bad++;
            $display("FAIL small_duty: duty=%h busy=%b, expected duty=%h busy=%b",
                     bus_if.duty, bus_if.ramp_busy, e.duty, e.busy);
        end
        wait_synch();
        capture_period();
        hi_cnt = 0;
        for (int c = 1; c < 2048; c++) hi_cnt += int'(hi_tr[c]);
        n_cmp++;
        if (hi_cnt !== 0) begin
            n_bad++; $display("FAIL short_pulse_swallowed: hi high for %0d clks, expected 0", hi_cnt);
        end
        n_cmp++;
        if (lo_tr[1] !== 1'b0 || lo_tr[11'h11+DT-1] !== 1'b0 || lo_tr[11'h11+DT] !== 1'b1) begin
            n_bad++; $display("FAIL short_pulse_lo: lo=%b,%b,%b, expected 0,0,1",
                              lo_tr[1], lo_tr[11'h11+DT-1], lo_tr[11'h11+DT]);
        end
    endtask

    task automatic test_brake();
        logic [10:0] d, t;
        exp_t e;
        wait_synch();
        bus_if.drv_mag = 12'h600;
        d = 11'h010;
        t = tgt_of(12'h600);
        for (int i = 0; i < 16 && d != t; i++) begin
            d = slew_of(d, t);
            sb_q.push_back('{duty: d, busy: (d != t)});
        end
        while (sb_q.size() > 0) begin
            wait_synch();
            e = sb_q.pop_front();
            n_cmp++;
            if (bus_if.duty !== e.duty || bus_if.ramp_busy !== e.busy) begin
                n_bad++;
                $display("FAIL ramp_to_300: duty=%h busy=%b, expected duty=%h busy=%b",
                         bus_if.duty, bus_if.ramp_busy, e.duty, e.busy);
            end
        end
        repeat (39) @(negedge clk);                 // cnt 40, high side on
        n_cmp++;
        if (bus_if.pwm_hi !== 1'b1) begin
            n_bad++; $display("FAIL pre_brake_hi: hi=%b, expected 1", bus_if.pwm_hi);
        end
        bus_if.brake_n = 1'b0;                      // together with en low: brake wins
        bus_if.en      = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus_if.pwm_hi !== 1'b0 || bus_if.pwm_lo !== 1'b0 || bus_if.duty !== 11'd0 || bus_if.ramp_busy !== 1'b0) begin
            n_bad++; $display("FAIL brake_entry: hi=%b lo=%b duty=%h busy=%b, expected 0/0/000/0",
                              bus_if.pwm_hi, bus_if.pwm_lo, bus_if.duty, bus_if.ramp_busy);
        end
        repeat (DT - 1) @(negedge clk);
        n_cmp++;
        if (bus_if.pwm_lo !== 1'b0) begin
            n_bad++; $display("FAIL brake_lo_early: lo=%b at +%0d, expected 0", bus_if.pwm_lo, DT);
        end
        @(negedge clk);
        n_cmp++;
        if (bus_if.pwm_lo !== 1'b1 || bus_if.pwm_hi !== 1'b0) begin
            n_bad++; $display("FAIL brake_lo_on: lo=%b hi=%b at +%0d, expected 1/0", bus_if.pwm_lo, bus_if.pwm_hi, DT + 1);
        end
        bus_if.brake_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus_if.pwm_lo !== 1'b0 || bus_if.pwm_hi !== 1'b0 || bus_if.ramp_busy !== 1'b0) begin
            n_bad++; $display("FAIL brake_release: lo=%b hi=%b busy=%b, expected 0/0/0",
                              bus_if.pwm_lo, bus_if.pwm_hi, bus_if.ramp_busy);
        end
        bus_if.en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus_if.ramp_busy !== 1'b1 || bus_if.duty !== 11'd0) begin
            n_bad++; $display("FAIL restart_ramp: busy=%b duty=%h, expected 1/000", bus_if.ramp_busy, bus_if.duty);
        end
        sb_q.push_back('{duty: slew_of(11'd0, t), busy: (slew_of(11'd0, t) != t)});
        wait_synch();
        e = sb_q.pop_front();
        n_cmp++;
        if (bus_if.duty !== e.duty || bus_if.ramp_busy !== e.busy) begin
            n_bad++;
            $display("FAIL restart_first_step: duty=%h busy=%b, expected duty=%h busy=%b",
                     bus_if.duty, bus_if.ramp_busy, e.duty, e.busy);
        end
    endtask

    task automatic test_en_drop();
        repeat (99) @(negedge clk);                 // cnt 100, duty 0x100
        n_cmp++;
        if (bus_if.pwm_hi !== 1'b1) begin
            n_bad++; $display("FAIL pre_drop_hi: hi=%b, expected 1", bus_if.pwm_hi);
        end
        bus_if.en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus_if.pwm_hi !== 1'b0 || bus_if.pwm_lo !== 1'b0 || bus_if.duty !== 11'd0 || bus_if.ramp_busy !== 1'b0) begin
            n_bad++; $display("FAIL en_drop: hi=%b lo=%b duty=%h busy=%b, expected 0/0/000/0",
                              bus_if.pwm_hi, bus_if.pwm_lo, bus_if.duty, bus_if.ramp_busy);
        end
        repeat (DT + 8) @(negedge clk);
        n_cmp++;
        if (bus_if.pwm_hi !== 1'b0 || bus_if.pwm_lo !== 1'b0) begin
            n_bad++; $display("FAIL idle_gates: hi=%b lo=%b, expected 0/0", bus_if.pwm_hi, bus_if.pwm_lo);
        end
    endtask

    task automatic test_reset_mid();
        bus_if.en = 1'b1;
        wait_synch();
        repeat (50) @(negedge clk);
        n_cmp++;
        if (bus_if.pwm_hi !== 1'b1 || bus_if.duty !== slew_of(11'd0, tgt_of(12'h600))) begin
            n_bad++; $display("FAIL pre_reset_state: hi=%b duty=%h, expected 1/%h",
                              bus_if.pwm_hi, bus_if.duty, slew_of(11'd0, tgt_of(12'h600)));
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus_if.pwm_hi, bus_if.pwm_lo, bus_if.pwm_synch, bus_if.ramp_busy, bus_if.duty} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_mid_run: hi=%b lo=%b synch=%b busy=%b duty=%h, expected all 0",
                     bus_if.pwm_hi, bus_if.pwm_lo, bus_if.pwm_synch, bus_if.ramp_busy, bus_if.duty);
        end
        bus_if.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus_if.duty !== 11'd0 || bus_if.ramp_busy !== 1'b0) begin
            n_bad++; $display("FAIL after_reset_release: duty=%h busy=%b, expected 000/0", bus_if.duty, bus_if.ramp_busy);
        end
    endtask

    task automatic test_no_overlap();
        n_cmp++;
        if (overlap_seen !== 1'b0) begin
            n_bad++; $display("FAIL gate_overlap: pwm_hi and pwm_lo were high together");
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_track_down();
        test_deadtime();
        test_brake();
        test_en_drop();
        test_reset_mid();
        test_no_overlap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
